// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic MAC array controllers.
package tpu_pkg;

  localparam int unsigned WEIGHT_W = 8;
  localparam int unsigned ACC_W    = 32;

  typedef enum logic {
    L_SHIFT,
    L_FULL
  } load_state_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_STREAM,
    C_DRAIN
  } comp_state_t;

endpackage

// File: rtl/valid_delay.sv
// Fixed-depth 1-bit delay line with synchronous reset; tracks data valid
// through a pipelined array column.
module valid_delay #(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  output logic valid_dly
);

  logic [DEPTH-1:0] sr;

  // Casting the widened concatenation drops the oldest bit, which also
  // covers DEPTH == 1 without a special case.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr <= DEPTH'({sr, valid});
    end
  end

  assign valid_dly = sr[DEPTH-1];

endmodule

// File: rtl/mac_array_ctrl.sv
// Sequencer for one column of chained MAC cells: shadow weight loading,
// weight swap, compute command streaming and drain tracking.
module mac_array_ctrl
  import tpu_pkg::*;
#(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned MAC_LAT = 2,
  parameter int unsigned LEN_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [WEIGHT_W-1:0] w_data,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                x_valid,
  output logic                x_ready,
  output logic                load_weight,
  output logic [WEIGHT_W-1:0] weight_in,
  output logic                swap_weights,
  output logic                run,
  output logic                out_valid,
  output logic                done,
  output logic                busy
);

  localparam int unsigned DRAIN = ROWS * MAC_LAT;
  localparam int unsigned CNT_W = $clog2(ROWS + 1);
  localparam int unsigned DRN_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(ROWS - 1);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN - 1);

  load_state_t      load_st;
  comp_state_t      comp_st;
  logic [CNT_W-1:0] shift_cnt;
  logic [LEN_W-1:0] remaining;
  logic [DRN_W-1:0] drain_cnt;
  logic             act_valid;

  // Loader: fills the shadow chain, then waits for compute to go idle to swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_st      <= L_SHIFT;
      shift_cnt    <= '0;
      w_ready      <= 1'b0;
      load_weight  <= 1'b0;
      weight_in    <= '0;
      swap_weights <= 1'b0;
      act_valid    <= 1'b0;
    end else begin
      load_weight  <= 1'b0;
      swap_weights <= 1'b0;
      unique case (load_st)
        L_SHIFT: begin
          w_ready <= 1'b1;
          if (w_valid && w_ready) begin
            load_weight <= 1'b1;
            weight_in   <= w_data;
            shift_cnt   <= shift_cnt + CNT_W'(1);
            if (shift_cnt == LAST_BEAT) begin
              load_st <= L_FULL;
              w_ready <= 1'b0;
            end
          end
        end
        L_FULL: begin
          w_ready <= 1'b0;
          if (comp_st == C_IDLE) begin
            swap_weights <= 1'b1;
            act_valid    <= 1'b1;
            load_st      <= L_SHIFT;
            shift_cnt    <= '0;
            w_ready      <= 1'b1;
          end
        end
        default: load_st <= L_SHIFT;
      endcase
    end
  end

  // A full shadow chain with compute idle means a swap is being decided this
  // cycle; block commands then and during the swap pulse so they see new weights.
  assign cmd_ready = (comp_st == C_IDLE) && act_valid &&
                     (load_st != L_FULL) && !swap_weights;

  assign run     = (comp_st == C_STREAM) && x_valid;
  assign x_ready = run;
  assign busy    = (comp_st != C_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      comp_st   <= C_IDLE;
      remaining <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (comp_st)
        C_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            remaining <= cmd_len;
            if (cmd_len == '0) begin
              comp_st   <= C_DRAIN;
              drain_cnt <= DRAIN_LAST;
              done      <= (DRAIN_LAST == '0);
            end else begin
              comp_st <= C_STREAM;
            end
          end
        end
        C_STREAM: begin
          if (x_valid) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              comp_st   <= C_DRAIN;
              drain_cnt <= DRAIN_LAST;
              done      <= (DRAIN_LAST == '0);
            end
          end
        end
        C_DRAIN: begin
          if (drain_cnt == '0) begin
            comp_st <= C_IDLE;
          end else begin
            drain_cnt <= drain_cnt - DRN_W'(1);
            done      <= (drain_cnt == DRN_W'(1));
          end
        end
        default: comp_st <= C_IDLE;
      endcase
    end
  end

  valid_delay #(
    .DEPTH(DRAIN)
  ) u_out_valid_dly (
    .clk      (clk),
    .rst      (rst),
    .valid    (run),
    .valid_dly(out_valid)
  );

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl: weight load/swap, streaming, stalls,
// deferred swap, zero-length commands and mid-stream reset.
module tb_mac_array_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [7:0]  w_data = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_len = '0;
  logic        x_valid = 1'b0;
  logic        x_ready;
  logic        load_weight;
  logic [7:0]  weight_in;
  logic        swap_weights;
  logic        run;
  logic        out_valid;
  logic        done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [8:0] obs;
  logic [8:0] e;
  logic [7:0] tile [4];
  logic       xp [7];

  mac_array_ctrl #(
    .ROWS   (4),
    .MAC_LAT(2),
    .LEN_W  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_data      (w_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .x_valid     (x_valid),
    .x_ready     (x_ready),
    .load_weight (load_weight),
    .weight_in   (weight_in),
    .swap_weights(swap_weights),
    .run         (run),
    .out_valid   (out_valid),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Bit order: w_ready cmd_ready x_ready load_weight swap_weights run out_valid done busy
  assign obs = {w_ready, cmd_ready, x_ready, load_weight, swap_weights,
                run, out_valid, done, busy};

  function automatic logic [8:0] ev(input bit w, input bit c, input bit r,
                                    input bit l, input bit s, input bit o,
                                    input bit d, input bit b);
    return {w, c, r, l, s, r, o, d, b};
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; w_valid = 1'b1; w_data = 8'hFF;
    cmd_valid = 1'b1; cmd_len = '1; x_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      #1;
      checks++;
      if (obs !== 9'b0 || weight_in !== 8'h00) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%b/%h exp=%b/00", i, obs, weight_in, 9'b0);
      end
    end
    rst = 1'b0; w_valid = 1'b0; w_data = '0;
    cmd_valid = 1'b0; cmd_len = '0; x_valid = 1'b0;
    next_cycle();
    #1;
    e = ev(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_release got=%b exp=%b", obs, e);
    end
  endtask

  task automatic test_load_swap;
    tile = '{8'd11, 8'd22, 8'd33, 8'd44};
    for (int k = 0; k < 7; k++) begin
      w_valid = (k < 4);
      w_data  = (k < 4) ? tile[k] : 8'h00;
      #1;
      e = ev((k < 4) || (k >= 5), k == 6, 0, (k >= 1) && (k <= 4), k == 5, 0, 0, 0);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL load cyc=%0d got=%b exp=%b", k, obs, e);
      end
      if (k >= 1 && k <= 4) begin
        checks++;
        if (weight_in !== tile[k-1]) begin
          errors++;
          $display("FAIL load_data cyc=%0d got=%0d exp=%0d", k, weight_in, tile[k-1]);
        end
      end
      next_cycle();
    end
    w_valid = 1'b0; w_data = '0;
  endtask

  task automatic test_stream3;
    for (int j = 0; j < 14; j++) begin
      cmd_valid = (j == 0); cmd_len = 16'd3; x_valid = 1'b1;
      #1;
      e = ev(1, (j == 0) || (j >= 12), (j >= 1) && (j <= 3), 0, 0,
             (j >= 9) && (j <= 11), j == 11, (j >= 1) && (j <= 11));
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL stream3 cyc=%0d got=%b exp=%b", j, obs, e);
      end
      next_cycle();
    end
    cmd_valid = 1'b0; x_valid = 1'b0;
  endtask

  task automatic test_stall_gaps;
    xp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int j = 0; j < 17; j++) begin
      cmd_valid = (j == 0); cmd_len = 16'd4;
      x_valid = (j >= 1 && j <= 7) ? xp[j-1] : 1'b0;
      #1;
      e = ev(1, (j == 0) || (j == 16),
             (j == 1) || (j == 4) || (j == 5) || (j == 7), 0, 0,
             (j == 9) || (j == 12) || (j == 13) || (j == 15),
             j == 15, (j >= 1) && (j <= 15));
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL stall cyc=%0d got=%b exp=%b", j, obs, e);
      end
      next_cycle();
    end
    cmd_valid = 1'b0; x_valid = 1'b0;
  endtask

  task automatic test_deferred_swap;
    tile = '{8'd5, 8'd6, 8'd7, 8'd8};
    for (int j = 0; j < 31; j++) begin
      w_valid   = (j >= 1) && (j <= 4);
      w_data    = (j >= 1 && j <= 4) ? tile[j-1] : 8'h00;
      cmd_valid = (j == 0) || (j == 20) || (j == 21);
      cmd_len   = (j == 0) ? 16'd10 : 16'd0;
      x_valid   = 1'b1;
      #1;
      e = ev((j <= 4) || (j >= 20), (j == 0) || (j == 21) || (j == 30),
             (j >= 1) && (j <= 10), (j >= 2) && (j <= 5), j == 20,
             (j >= 9) && (j <= 18), (j == 18) || (j == 29),
             ((j >= 1) && (j <= 18)) || ((j >= 22) && (j <= 29)));
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL deferred cyc=%0d got=%b exp=%b", j, obs, e);
      end
      if (j >= 2 && j <= 5) begin
        checks++;
        if (weight_in !== tile[j-2]) begin
          errors++;
          $display("FAIL deferred_data cyc=%0d got=%0d exp=%0d", j, weight_in, tile[j-2]);
        end
      end
      next_cycle();
    end
    w_valid = 1'b0; w_data = '0; cmd_valid = 1'b0; x_valid = 1'b0;
  endtask

  task automatic test_zero_len;
    for (int j = 0; j < 10; j++) begin
      cmd_valid = (j == 0); cmd_len = 16'd0; x_valid = 1'b1;
      #1;
      e = ev(1, (j == 0) || (j == 9), 0, 0, 0, 0, j == 8, (j >= 1) && (j <= 8));
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL zero_len cyc=%0d got=%b exp=%b", j, obs, e);
      end
      next_cycle();
    end
    cmd_valid = 1'b0; x_valid = 1'b0;
  endtask

  task automatic test_reset_mid_stream;
    // Accept a 5-beat command, take 2 beats while shifting 2 stray weights.
    for (int j = 0; j < 3; j++) begin
      cmd_valid = (j == 0); cmd_len = 16'd5; x_valid = 1'b1;
      w_valid = (j >= 1); w_data = 8'(j + 8);
      #1;
      e = ev(1, j == 0, j >= 1, j == 2, 0, 0, 0, j >= 1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL pre_reset cyc=%0d got=%b exp=%b", j, obs, e);
      end
      next_cycle();
    end
    rst = 1'b1; w_valid = 1'b0; cmd_valid = 1'b0; x_valid = 1'b0;
    next_cycle();
    w_valid = 1'b1; w_data = 8'hFF; cmd_valid = 1'b1; x_valid = 1'b1;
    #1;
    checks++;
    if (obs !== 9'b0 || weight_in !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got=%b/%h exp=%b/00", obs, weight_in, 9'b0);
    end
    next_cycle();
    rst = 1'b0; w_valid = 1'b0; w_data = '0; cmd_valid = 1'b0; x_valid = 1'b0;
    next_cycle();
    tile = '{8'd1, 8'd2, 8'd3, 8'd4};
    for (int k = 0; k < 16; k++) begin
      w_valid   = (k < 4);
      w_data    = (k < 4) ? tile[k] : 8'h00;
      cmd_valid = (k <= 6); cmd_len = 16'd0; x_valid = 1'b1;
      #1;
      e = ev((k < 4) || (k >= 5), (k == 6) || (k == 15), 0,
             (k >= 1) && (k <= 4), k == 5, 0, k == 14, (k >= 7) && (k <= 14));
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reload cyc=%0d got=%b exp=%b", k, obs, e);
      end
      if (k >= 1 && k <= 4) begin
        checks++;
        if (weight_in !== tile[k-1]) begin
          errors++;
          $display("FAIL reload_data cyc=%0d got=%0d exp=%0d", k, weight_in, tile[k-1]);
        end
      end
      next_cycle();
    end
    w_valid = 1'b0; w_data = '0; cmd_valid = 1'b0; x_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_swap();
    test_stream3();
    test_stall_gaps();
    test_deferred_swap();
    test_zero_len();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_array_ctrl.md
# mac_array_ctrl

Sequencing controller for one column of ROWS chained `mac` cells. It streams weights into the column's shadow registers over a shift chain and issues the swap that makes them active. It then runs compute commands of a given length over a data stream and reports when results have drained out of the column. Shadow weights for the next tile load while the current tile computes.

## Interface

Parameters:
- `ROWS`, 4: MACs in the column (weight shift-chain depth)
- `MAC_LAT`, 2: per-MAC latency in cycles
- `LEN_W`, 16: width of command length

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `w_valid`  in  1  weight beat valid
- `w_ready`  out  1  weight beat accepted when `w_valid && w_ready`
- `w_data`  in  8  weight value
- `cmd_valid`  in  1  compute command valid
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`
- `cmd_len`  in  LEN_W  number of data beats in the command
- `x_valid`  in  1  data source has a beat for the array
- `x_ready`  out  1  data beat consumed this cycle (equals `run`)
- `load_weight`  out  1  to array: shift `weight_in` into the shadow chain
- `weight_in`  out  8  to array: weight being shifted
- `swap_weights`  out  1  to array: shadow becomes active
- `run`  out  1  to array: MAC enable for this data beat
- `out_valid`  out  1  array bottom `acc_out` is valid this cycle
- `done`  out  1  one-cycle pulse: command fully drained
- `busy`  out  1  compute FSM not idle

## Operation

- Loader FSM, states L_SHIFT → L_FULL → L_SHIFT:
  - L_SHIFT: `w_ready=1`; on each handshake, `load_weight=1` and `weight_in=w_data` are registered for the next cycle. A shift counter increments per beat.
  - After the ROWS-th beat the FSM enters L_FULL and `w_ready=0`.
  - The first weight accepted ends in the deepest row.
- Swap:
  - Issued when loader is in L_FULL and compute is in C_IDLE. `swap_weights` is registered high for exactly 1 cycle.
  - On the swap, `act_valid` is set, the loader returns to L_SHIFT and the counter clears.
- Swap has priority over commands: `cmd_ready=0` in any cycle where a swap is being issued. A command arriving then therefore runs on the new weights.
- Compute FSM, states C_IDLE → C_STREAM → C_DRAIN → C_IDLE:
  - C_IDLE: `cmd_ready = act_valid && !swap_pending`. On accept, `cmd_len` is latched into a remaining-beat counter.
  - C_STREAM: on each cycle with `x_valid`, `run=1` and `x_ready=1`, and remaining decrements. When `x_valid=0`, `run=0` (stall, no timeout). After the last beat the FSM enters C_DRAIN.
  - `cmd_len=0`: the FSM goes directly C_IDLE → C_DRAIN; `run` is never asserted.
  - C_DRAIN: waits DRAIN = ROWS*MAC_LAT cycles, counted from the cycle after the last `run`. `done` pulses in the final drain cycle, and the FSM returns to C_IDLE the next cycle.
- `out_valid` is `run` delayed by exactly DRAIN cycles through a shift register. Stalls in `run` are preserved as gaps in `out_valid`.
- Active weights persist across any number of commands until the next swap.
- Weights may load in any compute state. The swap waits until compute returns to C_IDLE.

## Timing

- Reset (any cycle, including mid-load or mid-stream):
  - All outputs are 0: `w_ready`, `cmd_ready`, `x_ready`, `load_weight`, `weight_in=0`, `swap_weights`, `run`, `out_valid`, `done`, `busy`.
  - `act_valid=0`, both FSMs go to their initial states (L_SHIFT, C_IDLE), counters are 0, and the `out_valid` delay line is flushed.
  - `w_ready=1` from the first cycle after `rst` deasserts.
- `load_weight` and `weight_in` lag the weight handshake by 1 cycle. `run` and `x_ready` are combinational from state and `x_valid`.
- Earliest swap is 1 cycle after the final weight's `load_weight` cycle.
- Earliest `cmd_ready` is the cycle after `swap_weights`.
- `busy=1` from the cycle after command accept through the `done` cycle inclusive.
- Back-to-back commands: the next command can be accepted the cycle after `done`.

## Structure

- `tpu_pkg`:
  - constants `WEIGHT_W=8`, `ACC_W=32`
  - enums `load_state_t` {L_SHIFT, L_FULL} and `comp_state_t` {C_IDLE, C_STREAM, C_DRAIN}
- Sub-module `valid_delay` (parameter DEPTH), a 1-bit synchronous-reset shift register. It generates `out_valid` and is reusable for other array columns.

## Test plan

- Reset: hold `rst` 2 cycles with all inputs high. All outputs stay 0, and `cmd_ready=0` because no weights are active.
- Load weights 11, 22, 33, 44 back-to-back:
  - `load_weight` is high for 4 consecutive cycles, with `weight_in` = 11, 22, 33, 44.
  - `w_ready` drops after the 4th handshake.
  - `swap_weights` pulses once, then `cmd_ready=1`.
- `cmd_len=3` with `x_valid` held high:
  - `run` is high for 3 cycles.
  - `out_valid` is high for 3 cycles, starting 8 cycles after the first `run`.
  - `done` pulses 8 cycles after the last `run`.
  - `busy` deasserts the cycle after `done`.
- `cmd_len=4` with `x_valid` pattern 1,0,0,1,1,0,1:
  - `run` mirrors `x_valid` until 4 beats are taken.
  - `out_valid` reproduces the same gaps 8 cycles later.
- Second weight tile 5, 6, 7, 8 loaded during a `cmd_len=10` stream:
  - No swap occurs until after `done`.
  - A command presented the same cycle as the deferred swap is held off 1 cycle, then accepted.
- Boundaries:
  - `cmd_len=0` gives no `run` and `done` after 8 cycles.
  - `rst` asserted mid-stream (after 2 of 5 beats) clears everything, including `act_valid`. `cmd_ready` stays 0 until a new 4-weight load and swap complete.
